// File: rtl/cascade_pkg.sv
// Shared types for the adder/comparator cascade capture path.
// Capture entries are {carry, sum, stamp}; carry sits in the MSB.
package cascade_pkg;

  localparam int CAP_DW = 16;

  typedef struct packed {
    logic              carry;
    logic [CAP_DW-1:0] sum;
    logic [CAP_DW-1:0] stamp;
  } cap_entry_t;

  typedef enum logic [1:0] {IDLE, ARMED, DRAIN} cap_state_t;

endpackage

// File: rtl/match_fifo.sv
// Sync FIFO of cap_entry_t with a registered head; push-to-head latency 1 cycle.
// Push into a full FIFO is accepted only alongside a pop; otherwise the push is ignored.
module match_fifo
  import cascade_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cap_entry_t din,
  output cap_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  cap_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + 1'b1;

  // Storage needs no reset; only the pointers, count and head define visible state.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head tracks mem[rd_ptr]; a new entry lands directly in head when nothing older remains.
      if (do_pop) begin
        if (count > ONE_CNT) head <= mem[rd_nxt];
        else if (do_push)    head <= din;
        else                 head <= '0;
      end else if (do_push && empty) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/sum_match_capture.sv
// Captures {carry, sum, stamp} on each match while armed; match to out_valid is 1 cycle.
// Output is valid/ready; a match hitting a full FIFO is dropped and sets sticky overflow. Option: DROP_COUNT_EN.
module sum_match_capture
  import cascade_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DW      = CAP_DW,
  parameter int MAX_EVT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sum_in,
  input  logic          cout_in,
  input  logic          match_in,
  input  logic [DW-1:0] cnt_in,
  input  logic          arm,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*DW:0] out_data,
  output logic          overflow,
  output logic          busy
`ifdef DROP_COUNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  cap_state_t    state;
  cap_state_t    state_nxt;
  logic [DW-1:0] evt_cnt;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic          evt_hit;
  logic          start;
  cap_entry_t    din;
  cap_entry_t    head;

  // DW must equal CAP_DW, since entries use the shared cap_entry_t layout.
  assign din       = '{carry: cout_in, sum: sum_in, stamp: cnt_in};
  assign out_data  = head;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop      = 1'b0;
    evt_hit   = 1'b0;
    start     = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state_nxt = ARMED;
            start     = 1'b1;
          end
        end
        ARMED: begin
          if (match_in) begin
            evt_hit = 1'b1;
            if (!full || pop) push = 1'b1;
            else              drop = 1'b1;
            if (evt_cnt == DW'(MAX_EVT - 1)) state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (empty) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      evt_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start)        evt_cnt <= '0;
      else if (evt_hit) evt_cnt <= evt_cnt + 1'b1;
      if (start)        overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
    end
  end

`ifdef DROP_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          drop_cnt <= '0;
    else if (clr || start)            drop_cnt <= '0;
    else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
  end
`endif

  match_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clr),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

endmodule
